// File: rtl/imem_loader_pkg.sv
// +----------------------------------------------------------------------------+
// | imem_loader_pkg : shared processor constants and loader state encoding      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package imem_loader_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int BYTE_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_HI   = 3'd2,
    ST_LO   = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } ldr_state_t;

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// +----------------------------------------------------------------------------+
// | imem_loader_if : byte stream handshake plus instruction-memory write bus    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface imem_loader_if #(
  parameter int ADDR_W  = imem_loader_pkg::ADDR_W,
  parameter int INSTR_W = imem_loader_pkg::INSTR_W
);

  logic [imem_loader_pkg::BYTE_W-1:0] rx_data;
  logic                               rx_valid;
  logic                               rx_ready;
  logic                               imem_we;
  logic [ADDR_W-1:0]                  imem_waddr;
  logic [INSTR_W-1:0]                 imem_wdata;

  // master: stream source / memory sink side; slave: the loader itself
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_waddr, imem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// +----------------------------------------------------------------------------+
// | imem_loader : framed byte stream -> 16-bit instruction memory writes,       |
// |               holds the core in reset until a checksum-verified load.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module imem_loader #(
  parameter int ADDR_W  = imem_loader_pkg::ADDR_W,
  parameter int INSTR_W = imem_loader_pkg::INSTR_W
) (
  input  wire         clk,
  input  wire         rstn,
  input  wire         load_start,
  imem_loader_if.slave bus,
  output logic        core_rstn,
  output logic        busy,
  output logic        load_done,
  output logic        load_err
);

  import imem_loader_pkg::*;

  // One extra bit so a LEN of 0 (256 words) is representable without wrap
  localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

  ldr_state_t          r_state;
  ldr_state_t          w_next;

  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     r_widx;
  logic [BYTE_W-1:0]   r_sum;
  logic [BYTE_W-1:0]   r_hi;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [INSTR_W-1:0]  r_wdata;

  logic                w_accept;
  logic [ADDR_W:0]     w_widx_inc;
  logic                w_last_word;

  assign w_accept    = bus.rx_valid && bus.rx_ready;
  assign w_widx_inc  = r_widx + 1'b1;
  assign w_last_word = (w_widx_inc == r_count);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (load_start) w_next = ST_LEN;
      ST_LEN:  if (w_accept) w_next = ST_HI;
      ST_HI:   if (w_accept) w_next = ST_LO;
      ST_LO:   if (w_accept) w_next = w_last_word ? ST_CSUM : ST_HI;
      ST_CSUM: if (w_accept) w_next = (bus.rx_data == r_sum) ? ST_DONE : ST_ERR;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs are pure decodes of the registered state
  always_comb begin
    bus.rx_ready = 1'b0;
    busy         = 1'b0;
    core_rstn    = 1'b0;
    load_done    = 1'b0;
    load_err     = 1'b0;
    unique case (r_state)
      ST_LEN, ST_HI, ST_LO, ST_CSUM: begin
        bus.rx_ready = 1'b1;
        busy         = 1'b1;
      end
      ST_DONE: begin
        core_rstn = 1'b1;
        load_done = 1'b1;
      end
      ST_ERR:  load_err = 1'b1;
      default: ;
    endcase
  end

  // Byte assembler, word counter, checksum and registered write port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
      r_widx  <= '0;
      r_sum   <= '0;
      r_hi    <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        unique case (r_state)
          ST_LEN: begin
            r_count <= (bus.rx_data == '0) ? CNT_FULL : (ADDR_W+1)'(bus.rx_data);
            r_widx  <= '0;
            r_sum   <= '0;
          end
          ST_HI: begin
            r_hi  <= bus.rx_data;
            r_sum <= r_sum + bus.rx_data;
          end
          ST_LO: begin
            r_sum   <= r_sum + bus.rx_data;
            r_we    <= 1'b1;
            r_waddr <= r_widx[ADDR_W-1:0];
            r_wdata <= INSTR_W'({r_hi, bus.rx_data});
            r_widx  <= w_widx_inc;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.imem_we    = r_we;
  assign bus.imem_waddr = r_waddr;
  assign bus.imem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// +----------------------------------------------------------------------------+
// | tb_imem_loader : scoreboard bench for the program loader                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_imem_loader;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic load_start = 1'b0;
  logic core_rstn, busy, load_done, load_err;

  imem_loader_if bus();

  imem_loader dut (
    .clk        (clk),
    .rstn       (rstn),
    .load_start (load_start),
    .bus        (bus),
    .core_rstn  (core_rstn),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] exp_q[$];      // {addr, data} of writes still owed by the DUT
  logic [15:0] fw [0:255];    // words of the frame being sent
  logic [23:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && bus.imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", {31'b0, bus.imem_we}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("waddr", {24'b0, bus.imem_waddr}, {24'b0, mon_e[23:16]});
        check("wdata", {16'b0, bus.imem_wdata}, {16'b0, mon_e[15:0]});
      end
    end
  end

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  // Offer one byte after an optional random stall; returns 1 ns after the accepting edge
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int t;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    bus.rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    t = 0;
    @(negedge clk);
    while (!bus.rx_ready && t < 100) begin @(negedge clk); t++; end
    if (!bus.rx_ready) check("rx_ready_timeout", {31'b0, bus.rx_ready}, 32'd1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic load_frame(input int n, input bit bad, input int max_gap, input bit mid_start);
    logic [7:0] sum;
    logic [7:0] nb;
    logic [7:0] kb;
    sum = 8'd0;
    nb  = n[7:0];
    pulse_start();
    check("busy_start", {31'b0, busy}, 32'd1);
    check("done_clr", {31'b0, load_done}, 32'd0);
    check("err_clr", {31'b0, load_err}, 32'd0);
    send_byte(nb, max_gap);
    for (int k = 0; k < n; k++) begin
      if (mid_start && k == 1) begin
        pulse_start();
        check("busy_mid_start", {31'b0, busy}, 32'd1);
      end
      kb = k[7:0];
      send_byte(fw[k][15:8], max_gap);
      exp_q.push_back({kb, fw[k]});
      sum = sum + fw[k][15:8] + fw[k][7:0];
      send_byte(fw[k][7:0], max_gap);
    end
    check("core_rstn_pre_csum", {31'b0, core_rstn}, 32'd0);
    check("busy_pre_csum", {31'b0, busy}, 32'd1);
    send_byte(bad ? sum + 8'd1 : sum, max_gap);
    check("load_done", {31'b0, load_done}, {31'b0, !bad});
    check("load_err", {31'b0, load_err}, {31'b0, bad});
    check("core_rstn", {31'b0, core_rstn}, {31'b0, !bad});
    check("busy_end", {31'b0, busy}, 32'd0);
    check("rx_ready_end", {31'b0, bus.rx_ready}, 32'd0);
    check("writes_pending", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, {31'b0, bus.rx_ready}, 32'd0);
    check({tag, "_we"}, {31'b0, bus.imem_we}, 32'd0);
    check({tag, "_waddr"}, {24'b0, bus.imem_waddr}, 32'd0);
    check({tag, "_wdata"}, {16'b0, bus.imem_wdata}, 32'd0);
    check({tag, "_core_rstn"}, {31'b0, core_rstn}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, load_done}, 32'd0);
    check({tag, "_err"}, {31'b0, load_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rstn = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst_rel");

    // Byte offered in IDLE without a start is never consumed
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h02;
    repeat (6) @(posedge clk);
    #1;
    check("idle_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
    check("idle_core_rstn", {31'b0, core_rstn}, 32'd0);
    check("idle_busy", {31'b0, busy}, 32'd0);
    bus.rx_valid = 1'b0;

    // Basic two-word frame, good then bad checksum, then recovery
    fw[0] = 16'h1234;
    fw[1] = 16'hABCD;
    load_frame(2, 1'b0, 0, 1'b0);
    load_frame(2, 1'b1, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("err_hold_core_rstn", {31'b0, core_rstn}, 32'd0);
    load_frame(2, 1'b0, 0, 1'b0);

    // Full 256-word image
    for (int k = 0; k < 256; k++) fw[k] = {8'(2 * k), 8'(2 * k + 1)};
    load_frame(256, 1'b0, 0, 1'b0);

    // Random stalls with a start pulse while busy
    for (int k = 0; k < 8; k++) fw[k] = 16'(($urandom & 32'hFFFF));
    load_frame(8, 1'b0, 5, 1'b1);

    // Reset in the middle of word 1
    fw[0] = 16'h1111;
    fw[1] = 16'h2222;
    fw[2] = 16'h3333;
    pulse_start();
    send_byte(8'd3, 0);
    send_byte(fw[0][15:8], 0);
    exp_q.push_back({8'd0, fw[0]});
    send_byte(fw[0][7:0], 0);
    send_byte(fw[1][15:8], 0);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    check("rst_writes_pending", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    load_frame(3, 1'b0, 2, 1'b0);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
